// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue: program-ordered commit/trap record FIFO feeding the difftest sinks
module difftest_commit_queue #(
  parameter int DEPTH = 16,
  parameter int PC_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmt_valid,
  input  logic [PC_W-1:0]          cmt_pc,
  input  logic [31:0]              cmt_inst,
  input  logic                     cmt_rfwen,
  input  logic [4:0]               cmt_rd,
  input  logic                     cmt_skip,
  input  logic                     trap_valid,
  input  logic [PC_W-1:0]          trap_code,
  input  logic [PC_W-1:0]          trap_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_is_trap,
  output logic [PC_W-1:0]          out_pc,
  output logic [PC_W-1:0]          out_data,
  output logic                     out_rfwen,
  output logic [4:0]               out_rd,
  output logic                     out_skip,
  output logic [63:0]              out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  typedef struct packed {
    logic            is_trap;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] data;
    logic            rfwen;
    logic [4:0]      rd;
    logic            skip;
    logic [63:0]     seq;
  } rec_t;
  rec_t mem [DEPTH];
  rec_t head, cmt_rec, trap_rec;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [63:0] seq;
  logic [LW-1:0] free;
  logic cmt_store, trap_store, deq;
  assign out_valid = level != '0;
  // Admission uses start-of-cycle free space only; a same-cycle dequeue never makes room
  always_comb begin
    free = LW'(DEPTH) - level;
    cmt_store = cmt_valid && free != '0;
    trap_store = trap_valid && (cmt_valid ? free > LW'(1) : free != '0);
    deq = out_valid && out_ready;
    cmt_rec = '{is_trap: 1'b0, pc: cmt_pc, data: PC_W'(cmt_inst), rfwen: cmt_rfwen,
                rd: cmt_rd, skip: cmt_skip, seq: seq + 64'd1};
    trap_rec = '{is_trap: 1'b1, pc: trap_pc, data: trap_code, rfwen: 1'b0,
                 rd: 5'd0, skip: 1'b0, seq: seq + 64'(cmt_valid)};
    head = out_valid ? mem[rd_ptr] : '0;
  end
  assign {out_is_trap, out_pc, out_data, out_rfwen, out_rd, out_skip, out_seq} = head;
  // Record storage: commit first, trap in the slot after it when both are admitted
  always_ff @(posedge clock) begin
    if (cmt_store) mem[wr_ptr] <= cmt_rec;
    if (trap_store) mem[wr_ptr + PW'(cmt_store)] <= trap_rec;
  end
  // Pointers, occupancy, commit ordinal and sticky drop flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      seq <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(cmt_store) + PW'(trap_store);
      rd_ptr <= rd_ptr + PW'(deq);
      level <= level + LW'(cmt_store) + LW'(trap_store) - LW'(deq);
      seq <= seq + 64'(cmt_valid);
      overflow <= overflow | (cmt_valid & ~cmt_store) | (trap_valid & ~trap_store);
    end
  end
endmodule

// File: tb/tb_difftest_commit_queue.sv
// tb_difftest_commit_queue: randomized checks of the commit queue against a queue-based model
module tb_difftest_commit_queue;
  localparam int DEPTH = 16;
  logic clock = 0, reset = 1;
  logic cmt_valid = 0, cmt_rfwen = 0, cmt_skip = 0, trap_valid = 0, out_ready = 0;
  logic [63:0] cmt_pc = 0, trap_code = 0, trap_pc = 0;
  logic [31:0] cmt_inst = 0;
  logic [4:0] cmt_rd = 0;
  logic out_valid, out_is_trap, out_rfwen, out_skip, overflow;
  logic [63:0] out_pc, out_data, out_seq;
  logic [4:0] out_rd, level;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic        t;
    logic [63:0] pc;
    logic [63:0] data;
    logic        rf;
    logic [4:0]  rd;
    logic        sk;
    logic [63:0] seq;
  } rec_t;
  rec_t q[$];
  logic [63:0] m_seq = 0;
  logic m_ovf = 0;

  difftest_commit_queue #(.DEPTH(DEPTH), .PC_W(64)) dut (
    .clock(clock), .reset(reset), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
    .cmt_rfwen(cmt_rfwen), .cmt_rd(cmt_rd), .cmt_skip(cmt_skip), .trap_valid(trap_valid),
    .trap_code(trap_code), .trap_pc(trap_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_trap(out_is_trap), .out_pc(out_pc), .out_data(out_data), .out_rfwen(out_rfwen),
    .out_rd(out_rd), .out_skip(out_skip), .out_seq(out_seq), .level(level), .overflow(overflow));

  always #5 clock = ~clock;

  function automatic logic [206:0] dut_vec();
    return {out_valid, out_is_trap, out_pc, out_data, out_rfwen, out_rd, out_skip, out_seq, level, overflow};
  endfunction

  function automatic logic [206:0] mdl_vec();
    rec_t h = (q.size() != 0) ? q[0] : '0;
    return {q.size() != 0, h, 5'(q.size()), m_ovf};
  endfunction

  // Model advances on the same edge as the DUT, using the inputs held across it
  task automatic tick();
    int fr;
    if (reset) begin
      q.delete();
      m_seq = 0;
      m_ovf = 0;
    end else begin
      fr = DEPTH - q.size();
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (cmt_valid) begin
        m_seq++;
        if (fr > 0) begin
          q.push_back('{1'b0, cmt_pc, {32'b0, cmt_inst}, cmt_rfwen, cmt_rd, cmt_skip, m_seq});
          fr--;
        end else m_ovf = 1;
      end
      if (trap_valid) begin
        if (fr > 0) q.push_back('{1'b1, trap_pc, trap_code, 1'b0, 5'd0, 1'b0, m_seq});
        else m_ovf = 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic rand_fields();
    cmt_pc = {$urandom, $urandom};
    cmt_inst = $urandom;
    cmt_rfwen = 1'($urandom);
    cmt_rd = 5'($urandom);
    cmt_skip = 1'($urandom);
    trap_code = {$urandom, $urandom};
    trap_pc = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1;
    cmt_valid = 0;
    trap_valid = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    rand_fields();
    out_ready = 1;
    reset = 1;
    cmt_valid = 1;
    trap_valid = 1;
    tick();
    tick();
    checks++;
    if (dut_vec() !== 207'b0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", dut_vec());
    end
    reset = 0;
    cmt_valid = 0;
    trap_valid = 0;
  endtask

  task automatic test_single();
    do_reset();
    rand_fields();
    cmt_pc = 64'h80000004;
    cmt_inst = 32'h00000013;
    out_ready = 1;
    cmt_valid = 1;
    tick();
    cmt_valid = 0;
    checks++;
    if ({out_valid, out_is_trap, out_seq, out_pc, out_data} !== {1'b1, 1'b0, 64'd1, 64'h80000004, 64'h13}) begin
      errors++;
      $display("FAIL single_head got=%b %b %h %h %h want=1 0 1 80000004 13", out_valid, out_is_trap, out_seq, out_pc, out_data);
    end
    tick();
    checks++;
    if ({out_valid, level} !== 6'd0) begin
      errors++;
      $display("FAIL single_drain got valid=%b level=%0d want 0 0", out_valid, level);
    end
  endtask

  task automatic test_pair();
    do_reset();
    rand_fields();
    trap_code = 64'h8000000000000007;
    out_ready = 1;
    cmt_valid = 1;
    trap_valid = 1;
    tick();
    cmt_valid = 0;
    trap_valid = 0;
    checks++;
    if ({out_valid, out_is_trap, out_seq, level} !== {1'b1, 1'b0, 64'd1, 5'd2}) begin
      errors++;
      $display("FAIL pair_commit got=%b %b %0d %0d want=1 0 1 2", out_valid, out_is_trap, out_seq, level);
    end
    tick();
    checks++;
    if ({out_valid, out_is_trap, out_seq, out_data, out_rfwen, out_rd, out_skip} !==
        {1'b1, 1'b1, 64'd1, 64'h8000000000000007, 1'b0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL pair_trap got=%b %b %0d %h %b %0d %b", out_valid, out_is_trap, out_seq, out_data, out_rfwen, out_rd, out_skip);
    end
    tick();
    checks++;
    if (level !== 5'd0) begin
      errors++;
      $display("FAIL pair_drain level got=%0d want=0", level);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    out_ready = 0;
    cmt_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields();
      tick();
    end
    checks++;
    if ({level, overflow} !== {5'd16, 1'b0}) begin
      errors++;
      $display("FAIL fill_full got level=%0d ovf=%b want 16 0", level, overflow);
    end
    rand_fields();
    tick();
    cmt_valid = 0;
    checks++;
    if ({level, overflow} !== {5'd16, 1'b1}) begin
      errors++;
      $display("FAIL fill_drop got level=%0d ovf=%b want 16 1", level, overflow);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_seq !== 64'd1 || dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL fill_stall got seq=%0d vec=%h want seq=1 vec=%h", out_seq, dut_vec(), mdl_vec());
      end
    end
    out_ready = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (out_seq !== 64'(i) || dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL fill_drain got seq=%0d want=%0d vec=%h want=%h", out_seq, i, dut_vec(), mdl_vec());
      end
      tick();
    end
    checks++;
    if ({level, overflow} !== {5'd0, 1'b1}) begin
      errors++;
      $display("FAIL fill_sticky got level=%0d ovf=%b want 0 1", level, overflow);
    end
  endtask

  task automatic test_partial_drop();
    do_reset();
    out_ready = 0;
    cmt_valid = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      rand_fields();
      tick();
    end
    checks++;
    if ({level, overflow} !== {5'd15, 1'b0}) begin
      errors++;
      $display("FAIL partial_pre got level=%0d ovf=%b want 15 0", level, overflow);
    end
    rand_fields();
    trap_valid = 1;
    tick();
    cmt_valid = 0;
    trap_valid = 0;
    checks++;
    if ({level, overflow} !== {5'd16, 1'b1}) begin
      errors++;
      $display("FAIL partial_drop got level=%0d ovf=%b want 16 1", level, overflow);
    end
    out_ready = 1;
    while (q.size() != 0) begin
      checks++;
      if (dut_vec() !== mdl_vec() || out_is_trap !== 1'b0) begin
        errors++;
        $display("FAIL partial_drain got=%h want=%h", dut_vec(), mdl_vec());
      end
      tick();
    end
  endtask

  task automatic test_random_traffic();
    bit seen_skip = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      cmt_valid = ($urandom_range(0, 99) < 60);
      trap_valid = ($urandom_range(0, 99) < 15);
      out_ready = (i < 150) ? 1'(i & 1) : 1'($urandom);
      if (out_valid && out_skip && !out_is_trap) seen_skip = 1;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), mdl_vec());
      end
      tick();
    end
    cmt_valid = 0;
    trap_valid = 0;
    checks++;
    if (!seen_skip) begin
      errors++;
      $display("FAIL random_skip got out_skip never 1 want seen");
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    out_ready = 0;
    cmt_valid = 1;
    trap_valid = 1;
    rand_fields();
    tick();
    trap_valid = 0;
    tick();
    tick();
    tick();
    cmt_valid = 0;
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL midreset_pre level got=%0d want=5", level);
    end
    out_ready = 1;
    do_reset();
    checks++;
    if (dut_vec() !== 207'b0) begin
      errors++;
      $display("FAIL midreset_clear got=%h want=0", dut_vec());
    end
    cmt_valid = 1;
    rand_fields();
    tick();
    cmt_valid = 0;
    checks++;
    if ({out_valid, out_seq} !== {1'b1, 64'd1}) begin
      errors++;
      $display("FAIL midreset_seq got valid=%b seq=%0d want 1 1", out_valid, out_seq);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_fill_overflow();
    test_partial_drop();
    test_random_traffic();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
